// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: pin conditioning, 11-bit deframer, timeout and FWFT FIFO.
// Define PS2_RX_DECODE_EN to fold E0/F0 prefixes into {ext, brk} flags.
module ps2_rx_fifo #(
  parameter int DEPTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [9:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  logic [3:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_start;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          r_ferr;

  logic          w_bit;
  logic          w_sample;
  logic          w_last;
  logic          w_ok;
  logic          w_byte_v;
  logic          w_to;
  logic          w_ferr_set;
  logic          w_push;
  logic [9:0]    w_wdata;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_ovf_set;

  assign w_bit = r_dat_s[1];

  // Two-flop synchronisers, idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk};
      r_dat_s <= {r_dat_s[0], ps2_data};
    end
  end

  // Clock filter: flip only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s[1] == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
      r_filt <= r_clk_s[1];
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_sample = r_filt && !r_clk_s[1]
                 && (r_fcnt == FW'(FILTER_LEN - 1));

  assign w_last   = w_sample && (r_bitcnt == 4'd10);
  assign w_ok     = !r_start && (^{r_shift, r_par}) && w_bit;
  assign w_byte_v = w_last && w_ok;
  assign w_to     = (r_bitcnt != 4'd0) && !w_sample
                 && (r_tcnt == TW'(TIMEOUT - 1));
  assign w_ferr_set = (w_last && !w_ok) || w_to;

  // Deframer: bit counter and start/data/parity capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= 4'd0;
      r_shift  <= 8'h00;
      r_start  <= 1'b0;
      r_par    <= 1'b0;
    end else if (w_to) begin
      r_bitcnt <= 4'd0;
    end else if (w_sample) begin
      if (r_bitcnt == 4'd10)
        r_bitcnt <= 4'd0;
      else
        r_bitcnt <= r_bitcnt + 4'd1;
      if (r_bitcnt == 4'd0)
        r_start <= w_bit;
      else if (r_bitcnt <= 4'd8)
        r_shift <= {w_bit, r_shift[7:1]};
      else if (r_bitcnt == 4'd9)
        r_par <= w_bit;
    end
  end

  // Intra-frame gap counter, restarted by every sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tcnt <= '0;
    else if (r_bitcnt == 4'd0 || w_sample)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + 1'b1;
  end

`ifdef PS2_RX_DECODE_EN
  logic r_ext;
  logic r_brk;
  logic w_pfx;

  assign w_pfx   = (r_shift == 8'hE0) || (r_shift == 8'hF0);
  assign w_push  = w_byte_v && !w_pfx;
  assign w_wdata = {r_ext, r_brk, r_shift};

  // Pending prefix flags; cleared by a consumed byte or a bad frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_ferr_set) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_v) begin
      if (r_shift == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_shift == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end
`else
  assign w_push  = w_byte_v;
  assign w_wdata = {2'b00, r_shift};
`endif

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_rd      = rd_en && (r_level != '0);
  assign w_wr      = w_push && (!w_full || w_rd);
  assign w_ovf_set = w_push && w_full && !w_rd;

  // FIFO storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= w_wdata;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_rd)
        r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)
        r_level <= r_level + 1'b1;
      else if (!w_wr && w_rd)
        r_level <= r_level - 1'b1;
    end
  end

  // Sticky error flags; a set beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (clr_err)
        r_ovf <= 1'b0;
      if (w_ferr_set)
        r_ferr <= 1'b1;
      else if (clr_err)
        r_ferr <= 1'b0;
    end
  end

  assign rd_data   = r_mem[r_rptr];
  assign rd_valid  = (r_level != '0);
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo (DEPTH=4, FILTER_LEN=4, TIMEOUT=300).
// Table of frames plus hand-written corner-case sequences.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int TOUT  = 300;
  localparam int HALF  = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic [2:0] level;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  ps2_rx_fifo #(
    .DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .level(level), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] code;
    logic [1:0] kind;
    logic       exp_ferr;
    logic [2:0] exp_lvl;
    logic [9:0] exp_data;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  function automatic logic [10:0] mk(input logic [7:0] c,
                                     input logic [1:0] kind);
    logic st, par, sp;
    st  = (kind == 2'd3);
    par = ~(^c) ^ (kind == 2'd1);
    sp  = (kind != 2'd2);
    return {sp, par, c, st};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = b[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] c, input logic [1:0] k);
    send_bits(mk(c, k), 11);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  vec_t vt [8];

  initial begin
    logic [10:0] f;
    int n;

    vt[0] = '{8'h1C, 2'd0, 1'b0, 3'd1, 10'h01C};
    vt[1] = '{8'h1C, 2'd1, 1'b1, 3'd0, 10'h000};
    vt[2] = '{8'h1C, 2'd0, 1'b0, 3'd1, 10'h01C};
    vt[3] = '{8'h29, 2'd2, 1'b1, 3'd0, 10'h000};
    vt[4] = '{8'h29, 2'd0, 1'b0, 3'd1, 10'h029};
    vt[5] = '{8'h5A, 2'd3, 1'b1, 3'd0, 10'h000};
    vt[6] = '{8'hFF, 2'd0, 1'b0, 3'd1, 10'h0FF};
    vt[7] = '{8'h00, 2'd0, 1'b0, 3'd1, 10'h000};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Stop-sample latency of frame 0x1C.
    f = mk(8'h1C, 2'd0);
    send_bits(f, 10);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    while (!rd_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lat_range", 32'(n >= 5 && n <= 8), 32'd1);
    chk("lat_data", 32'(rd_data), 32'h01C);
    chk("lat_level", 32'(level), 32'd1);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    pop();
    chk("pop_level", 32'(level), 32'd0);
    chk("pop_valid", 32'(rd_valid), 32'd0);

    // Table of single frames.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].code, vt[i].kind);
      @(negedge clk);
      chk($sformatf("v%0d_ferr", i), 32'(frame_err),
          32'(vt[i].exp_ferr));
      chk($sformatf("v%0d_lvl", i), 32'(level),
          32'(vt[i].exp_lvl));
      if (vt[i].exp_lvl != 3'd0) begin
        chk($sformatf("v%0d_data", i), 32'(rd_data),
            32'(vt[i].exp_data));
        pop();
      end
      if (vt[i].exp_ferr) begin
        clr();
        chk($sformatf("v%0d_clr", i), 32'(frame_err), 32'd0);
      end
    end

    // Prefix handling.
    send(8'hE0, 2'd0);
    send(8'hF0, 2'd0);
    send(8'h75, 2'd0);
    @(negedge clk);
`ifdef PS2_RX_DECODE_EN
    chk("dec_lvl", 32'(level), 32'd1);
    chk("dec_data", 32'(rd_data), 32'h375);
    pop();
`else
    chk("raw_lvl", 32'(level), 32'd3);
    chk("raw_d0", 32'(rd_data), 32'h0E0);
    pop();
    chk("raw_d1", 32'(rd_data), 32'h0F0);
    pop();
    chk("raw_d2", 32'(rd_data), 32'h075);
    pop();
`endif
    chk("pfx_empty", 32'(level), 32'd0);

    // Overflow with DEPTH=4.
    for (int i = 0; i < 5; i++)
      send(8'h11 + 8'(i), 2'd0);
    @(negedge clk);
    chk("ovf_lvl", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_rd%0d", i), 32'(rd_data),
          32'h011 + 32'(i));
      pop();
    end
    chk("ovf_empty", 32'(level), 32'd0);
    chk("ovf_ferr", 32'(frame_err), 32'd0);
    clr();
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Timeout mid-frame.
    send_bits(mk(8'h29, 2'd0), 5);
    chk("to_early", 32'(frame_err), 32'd0);
    repeat (TOUT) @(negedge clk);
    chk("to_ferr", 32'(frame_err), 32'd1);
    chk("to_lvl", 32'(level), 32'd0);
    clr();
    send(8'h29, 2'd0);
    @(negedge clk);
    chk("to_next", 32'(rd_data), 32'h029);
    chk("to_nferr", 32'(frame_err), 32'd0);
    pop();

    // Reset during a frame, with one entry held.
    send(8'h33, 2'd0);
    send_bits(mk(8'hC3, 2'd0), 7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(rd_valid), 32'd0);
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    chk("mr_ferr", 32'(frame_err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h5A, 2'd0);
    @(negedge clk);
    chk("mr_lvl", 32'(level), 32'd1);
    chk("mr_data", 32'(rd_data), 32'h05A);
    chk("mr_nferr", 32'(frame_err), 32'd0);
    pop();

    // 2-cycle clock glitch must not count as a bit.
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("gl_lvl", 32'(level), 32'd0);
    send(8'h1C, 2'd0);
    @(negedge clk);
    chk("gl_data", 32'(rd_data), 32'h01C);
    chk("gl_lvl1", 32'(level), 32'd1);
    chk("gl_ferr", 32'(frame_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
